// File: rtl/count_ctrl_pkg.sv
// count_ctrl_pkg: shared state encoding and default widths for the count controller
package count_ctrl_pkg;
  localparam int WIDTH_DEF = 8;
  localparam int PRESCALE_W_DEF = 4;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;
  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN = ST_RUN,
    DONE = ST_DONE
  } state_t;
endpackage

// File: rtl/count_prescaler.sv
// count_prescaler: free-running divider that ticks when its count reaches the period value
module count_prescaler #(
  parameter int PRESCALE_W = 4
) (
  input logic clock,
  input logic reset,
  input logic clear,
  input logic [PRESCALE_W-1:0] period,
  output logic tick
);
  logic [PRESCALE_W-1:0] cnt;
  assign tick = cnt == period;
  // count up, wrap on tick, hold at zero while cleared
  always_ff @(posedge clock or posedge reset)
    if (reset) cnt <= '0;
    else cnt <= (clear || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/count_controller.sv
// count_controller: latch/dec/zero sequencer turning a down counter into a timer (optional COUNT_CTRL_AUTORELOAD_EN adds periodic mode)
module count_controller
  import count_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int PRESCALE_W = PRESCALE_W_DEF
) (
  input logic clock,
  input logic reset,
  input logic start,
  input logic [WIDTH-1:0] load_value,
  input logic [PRESCALE_W-1:0] prescale,
  input logic abort,
  input logic zero,
`ifdef COUNT_CTRL_AUTORELOAD_EN
  input logic periodic,
`endif
  output logic [WIDTH-1:0] count_in,
  output logic latch,
  output logic dec,
  output logic busy,
  output logic done
);
  state_t state, state_nxt;
  logic [PRESCALE_W-1:0] p_reg;
  logic tick;
  logic reload;
`ifdef COUNT_CTRL_AUTORELOAD_EN
  // re-latching from DONE skips LOAD so the period stays N(P+1)+2
  assign reload = periodic && !abort;
`else
  assign reload = 1'b0;
`endif
  count_prescaler #(.PRESCALE_W(PRESCALE_W)) u_pre (
    .clock(clock),
    .reset(reset),
    .clear(state != RUN),
    .period(p_reg),
    .tick(tick)
  );
  // state register
  always_ff @(posedge clock or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nxt;
  // capture the load value and period only when a start is accepted
  always_ff @(posedge clock or posedge reset)
    if (reset) begin
      count_in <= '0;
      p_reg <= '0;
    end else if (state == IDLE && start) begin
      count_in <= load_value;
      p_reg <= prescale;
    end
  // next state; abort wins over zero in RUN, start wins over abort in IDLE
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start ? LOAD : IDLE;
      LOAD: state_nxt = abort ? IDLE : RUN;
      RUN: state_nxt = abort ? IDLE : zero ? DONE : RUN;
      DONE: state_nxt = reload ? RUN : IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  assign latch = state == LOAD || (state == DONE && reload);
  assign dec = state == RUN && tick && !zero;
  assign busy = state != IDLE;
  assign done = state == DONE;
endmodule
